sound_comm_latch: RTL

SOUND_COMM_LATCH -- requirements
Module: sound_comm_latch

---
 rtl/neo_comm_pkg.sv | 13 +
 rtl/strobe_sync.sv | 35 +++
 rtl/sound_comm_latch.sv | 121 ++++++++++++
 3 files changed

// File: rtl/neo_comm_pkg.sv
// Shared types and constants for the 68k <-> Z80 sound command/reply latch.
// Optional status outputs are enabled by defining COMM_STATUS_EN.
package neo_comm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } comm_state_e;

    localparam int         SYNC_STAGES = 2;
    localparam logic [3:0] OVR_MAX     = 4'd15;

endpackage

// File: rtl/strobe_sync.sv
// Synchronizes an active-low asynchronous strobe and emits a one-cycle
// pulse on its falling edge. All flops reset high so release is silent.
module strobe_sync
    import neo_comm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic strobe_n,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], strobe_n};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Pulse comes from flops only, so it never follows the pin combinationally.
    assign pulse = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sound_comm_latch.sv
// Command/reply mailbox between the 68k and the sound Z80, with NMI request.
// Define COMM_STATUS_EN to expose CMD_PEND, REP_FRESH and OVR_CNT.
module sound_comm_latch
    import neo_comm_pkg::*;
(
    input  logic       CLK_24M,
    input  logic       RESET,
    input  logic       nSNDCMDWR,
    input  logic       nSNDREPRD,
    input  logic [7:0] M68K_DATA_IN,
    output logic [7:0] M68K_DATA_OUT,
    input  logic       nSDZ80R,
    input  logic       nSDZ80W,
    input  logic       nSDZ80CLR,
    input  logic [7:0] SDD_IN,
    output logic [7:0] SDD_OUT,
    output logic       NMI_REQ
`ifdef COMM_STATUS_EN
    ,
    output logic       CMD_PEND,
    output logic       REP_FRESH,
    output logic [3:0] OVR_CNT
`endif
);

    logic cmd_wr_p;
    logic rep_rd_p;
    logic z_rd_p;
    logic z_wr_p;
    logic z_clr_p;

    strobe_sync u_cmd_wr (
        .clk(CLK_24M), .rst(RESET), .strobe_n(nSNDCMDWR), .pulse(cmd_wr_p)
    );
    strobe_sync u_rep_rd (
        .clk(CLK_24M), .rst(RESET), .strobe_n(nSNDREPRD), .pulse(rep_rd_p)
    );
    strobe_sync u_z_rd (
        .clk(CLK_24M), .rst(RESET), .strobe_n(nSDZ80R), .pulse(z_rd_p)
    );
    strobe_sync u_z_wr (
        .clk(CLK_24M), .rst(RESET), .strobe_n(nSDZ80W), .pulse(z_wr_p)
    );
    strobe_sync u_z_clr (
        .clk(CLK_24M), .rst(RESET), .strobe_n(nSDZ80CLR), .pulse(z_clr_p)
    );

    comm_state_e state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  rep_q, rep_d;
    logic        fresh_q, fresh_d;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        rep_d   = rep_q;
        fresh_d = fresh_q;

        // A 68k write beats a same-cycle Z80 clear or read.
        if (cmd_wr_p) begin
            cmd_d   = M68K_DATA_IN;
            state_d = PEND;
        end else if (z_clr_p) begin
            cmd_d   = 8'h00;
            state_d = IDLE;
        end else if (z_rd_p) begin
            state_d = IDLE;
        end

        if (z_wr_p) begin
            rep_d   = SDD_IN;
            fresh_d = 1'b1;
        end else if (rep_rd_p) begin
            fresh_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            state_q <= IDLE;
            cmd_q   <= 8'h00;
            rep_q   <= 8'h00;
            fresh_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            rep_q   <= rep_d;
            fresh_q <= fresh_d;
        end
    end

    assign SDD_OUT       = cmd_q;
    assign M68K_DATA_OUT = rep_q;
    assign NMI_REQ       = (state_q == PEND);

`ifdef COMM_STATUS_EN
    logic       overrun;
    logic [3:0] ovr_q, ovr_d;

    always_comb begin
        overrun = cmd_wr_p && (state_q == PEND) && !z_rd_p;
        ovr_d   = ovr_q;
        if (overrun && (ovr_q != OVR_MAX)) begin
            ovr_d = ovr_q + 4'd1;
        end
    end

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            ovr_q <= 4'd0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign CMD_PEND  = (state_q == PEND);
    assign REP_FRESH = fresh_q;
    assign OVR_CNT   = ovr_q;
`endif

endmodule
